dac_sequencer: RTL and testbench

DAC_SEQUENCER -- requirements
Module: dac_sequencer

---
 rtl/dac_sequencer.sv | 159 +++++++++++++++
 tb/tb_dac_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_sequencer.sv
// Two-channel DAC sample sequencer: a prescaled sample tick drives a shared data bus
// and per-channel write strobes, with ramp, triangle and square waveform generators.
module dac_sequencer #(
    parameter int unsigned DW = 10,
    parameter int unsigned PW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic          cfg_chan,
    input  logic [1:0]    cfg_mode,
    input  logic [DW-1:0] cfg_step,
    input  logic [PW-1:0] cfg_div,
    output logic [DW-1:0] dac_data,
    output logic          dac_wr_a,
    output logic          dac_wr_b,
    output logic          busy
);

    typedef enum logic [2:0] {IDLE, WAIT, SETUP_A, WRITE_A, SETUP_B, WRITE_B} state_t;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RAMP = 2'b01;
    localparam logic [1:0] MODE_TRI  = 2'b10;
    localparam logic [1:0] MODE_SQR  = 2'b11;

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] lim_q, lim_d;
    logic [PW-1:0] cfg_div_q, cfg_div_d;
    logic [1:0]    mode_q [2];
    logic [1:0]    mode_d [2];
    logic [DW-1:0] step_q [2];
    logic [DW-1:0] step_d [2];
    logic [DW-1:0] val_q  [2];
    logic [DW-1:0] val_d  [2];
    logic [1:0]    dir_q, dir_d;   // 1 = counting down
    logic [DW-1:0] dac_data_q, dac_data_d;
    logic          wr_a_q, wr_a_d, wr_b_q, wr_b_d, busy_q, busy_d;

    logic          tick, accept, adv;
    logic [DW:0]   sum;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lim_d      = lim_q;
        cfg_div_d  = cfg_div_q;
        mode_d     = mode_q;
        step_d     = step_q;
        val_d      = val_q;
        dir_d      = dir_q;
        dac_data_d = dac_data_q;
        adv        = 1'b0;
        sum        = '0;

        tick      = (state_q != IDLE) && (cnt_q == lim_q);
        cfg_ready = (state_q == IDLE) || ((state_q == WAIT) && !tick);
        accept    = cfg_valid && cfg_ready;

        // Enable takes priority over the tick in WAIT so a stop request is never delayed.
        case (state_q)
            IDLE:    if (enable) state_d = WAIT;
            WAIT:    if (!enable) state_d = IDLE;
                     else if (tick) state_d = SETUP_A;
            SETUP_A: state_d = WRITE_A;
            WRITE_A: state_d = SETUP_B;
            SETUP_B: state_d = WRITE_B;
            WRITE_B: state_d = enable ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase

        cnt_d = (state_q == IDLE || state_d == IDLE || tick) ? '0 : cnt_q + PW'(1);

        if (accept) begin
            cfg_div_d        = cfg_div;
            mode_d[cfg_chan] = cfg_mode;
            step_d[cfg_chan] = cfg_step;
            val_d[cfg_chan]  = '0;
            dir_d[cfg_chan]  = 1'b0;
        end

        // The active limit only changes at a wrap (or while idle) so the count never skips past it.
        if (state_q == IDLE || tick)
            lim_d = (cfg_div_d < PW'(3)) ? PW'(3) : cfg_div_d;

        for (int unsigned i = 0; i < 2; i++) begin
            adv = (i == 0) ? (state_q == WRITE_A) : (state_q == WRITE_B);
            sum = {1'b0, val_q[i]} + {1'b0, step_q[i]};
            if (adv) begin
                case (mode_q[i])
                    MODE_RAMP: val_d[i] = sum[DW-1:0];
                    MODE_TRI: begin
                        if (!dir_q[i]) begin
                            if (sum >= {1'b0, {DW{1'b1}}}) begin
                                val_d[i] = '1;
                                dir_d[i] = 1'b1;
                            end else begin
                                val_d[i] = sum[DW-1:0];
                            end
                        end else if (val_q[i] <= step_q[i]) begin
                            val_d[i] = '0;
                            dir_d[i] = 1'b0;
                        end else begin
                            val_d[i] = val_q[i] - step_q[i];
                        end
                    end
                    MODE_SQR: val_d[i] = (val_q[i] == '0) ? '1 : '0;
                    default:  val_d[i] = val_q[i];
                endcase
            end
        end

        if (state_d == SETUP_A) dac_data_d = val_q[0];
        if (state_d == SETUP_B) dac_data_d = val_q[1];
        wr_a_d = (state_d == WRITE_A) && (mode_q[0] != MODE_OFF);
        wr_b_d = (state_d == WRITE_B) && (mode_q[1] != MODE_OFF);
        busy_d = (state_d == SETUP_A) || (state_d == WRITE_A) ||
                 (state_d == SETUP_B) || (state_d == WRITE_B);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lim_q      <= PW'(3);
            cfg_div_q  <= PW'(3);
            mode_q     <= '{default: MODE_OFF};
            step_q     <= '{default: '0};
            val_q      <= '{default: '0};
            dir_q      <= '0;
            dac_data_q <= '0;
            wr_a_q     <= 1'b0;
            wr_b_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lim_q      <= lim_d;
            cfg_div_q  <= cfg_div_d;
            mode_q     <= mode_d;
            step_q     <= step_d;
            val_q      <= val_d;
            dir_q      <= dir_d;
            dac_data_q <= dac_data_d;
            wr_a_q     <= wr_a_d;
            wr_b_q     <= wr_b_d;
            busy_q     <= busy_d;
        end
    end

    assign dac_data = dac_data_q;
    assign dac_wr_a = wr_a_q;
    assign dac_wr_b = wr_b_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_dac_sequencer.sv
// Directed self-checking bench for dac_sequencer: waveform sequences, strobe timing,
// enable drop mid-sequence, reset priority and config handshake around a tick.
module tb_dac_sequencer;

    localparam int unsigned DW = 10;
    localparam int unsigned PW = 16;

    logic          clk = 1'b0;
    logic          reset, enable, cfg_valid, cfg_ready, cfg_chan;
    logic [1:0]    cfg_mode;
    logic [DW-1:0] cfg_step;
    logic [PW-1:0] cfg_div;
    logic [DW-1:0] dac_data;
    logic          dac_wr_a, dac_wr_b, busy;

    int unsigned   cyc = 0;
    int unsigned   na = 0, nb = 0;
    int unsigned   nchk = 0, nerr = 0;

    dac_sequencer #(.DW(DW), .PW(PW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
        .cfg_mode(cfg_mode), .cfg_step(cfg_step), .cfg_div(cfg_div),
        .dac_data(dac_data), .dac_wr_a(dac_wr_a), .dac_wr_b(dac_wr_b), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (dac_wr_a) na++;
        if (dac_wr_b) nb++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called and returns at a negedge.
    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_cfg(input logic ch, input logic [1:0] m, input logic [DW-1:0] s,
                          input logic [PW-1:0] dv);
        cfg_chan = ch; cfg_mode = m; cfg_step = s; cfg_div = dv; cfg_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (cfg_ready) begin
                @(negedge clk);
                cfg_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        nerr++;
        $display("FAIL cfg_timeout: cfg_ready never seen");
    endtask

    task automatic wait_wr(input logic ch, output logic [DW-1:0] d,
                           output logic [DW-1:0] prev, output int unsigned at);
        prev = 'x;
        d = 'x;
        at = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ch ? dac_wr_b : dac_wr_a) begin
                d = dac_data;
                at = cyc;
                return;
            end
            prev = dac_data;
        end
        nerr++;
        $display("FAIL strobe_timeout: channel %0d strobe not seen", ch);
    endtask

    logic [DW-1:0] d, prev;
    int unsigned   at, last_at, t0, nb0, na0;
    logic [DW-1:0] exp_tri [8] = '{10'd0, 10'd400, 10'd800, 10'd1023, 10'd623, 10'd223, 10'd0, 10'd400};
    logic [DW-1:0] exp_sqa [3] = '{10'd0, 10'd1023, 10'd0};
    logic [DW-1:0] exp_wrp [4] = '{10'd0, 10'd512, 10'd0, 10'd512};

    initial begin
        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_chan = 1'b0;
        cfg_mode = '0; cfg_step = '0; cfg_div = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_data", dac_data, 0);
        check("rst_wr_a", dac_wr_a, 0);
        check("rst_wr_b", dac_wr_b, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cfg_ready, 1);

        // Ramp A, period 10, no B strobes
        do_cfg(1'b0, 2'b01, 10'd1, 16'd9);
        nb0 = nb;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_wr(1'b0, d, prev, at);
            check("ramp_a_data", d, i);
            check("ramp_a_setup", prev, i);
            if (i > 0) check("ramp_a_period", at - last_at, 10);
            last_at = at;
        end
        check("ramp_a_no_b", nb - nb0, 0);

        // Ramp wrap
        do_reset();
        do_cfg(1'b0, 2'b01, 10'd512, 16'd9);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_wr(1'b0, d, prev, at);
            check("wrap_a", d, exp_wrp[i]);
        end

        // Triangle B, A off
        do_reset();
        do_cfg(1'b1, 2'b10, 10'd400, 16'd9);
        na0 = na;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_wr(1'b1, d, prev, at);
            check("tri_b", d, exp_tri[i]);
        end
        check("tri_no_a", na - na0, 0);

        // Square A with ramp B step 3
        do_reset();
        do_cfg(1'b0, 2'b11, 10'd77, 16'd9);
        do_cfg(1'b1, 2'b01, 10'd3, 16'd9);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_wr(1'b0, d, prev, at);
            check("sq_a", d, exp_sqa[i]);
            last_at = at;
            wait_wr(1'b1, d, prev, at);
            check("ramp_b3", d, 3 * i);
            check("a_to_b_gap", at - last_at, 2);
        end

        // Enable dropped in SETUP_A: sequence completes, then idle
        do_reset();
        do_cfg(1'b0, 2'b01, 10'd1, 16'd9);
        do_cfg(1'b1, 2'b01, 10'd2, 16'd9);
        enable = 1'b1;
        for (int k = 0; k < 40 && !(busy && !dac_wr_a && !dac_wr_b); k++) @(negedge clk);
        check("drop_in_setup_a", busy, 1);
        enable = 1'b0;
        @(negedge clk);
        check("drop_wr_a", dac_wr_a, 1);
        check("drop_data_a", dac_data, 0);
        @(negedge clk);
        check("drop_setup_b_busy", busy, 1);
        @(negedge clk);
        check("drop_wr_b", dac_wr_b, 1);
        @(negedge clk);
        check("drop_idle_busy", busy, 0);
        check("drop_idle_ready", cfg_ready, 1);
        na0 = na; nb0 = nb;
        repeat (25) @(negedge clk);
        check("drop_no_strobes", (na - na0) + (nb - nb0), 0);
        // Prescaler restarted from 0: first strobe 12 cycles after enable
        enable = 1'b1;
        t0 = cyc;
        wait_wr(1'b0, d, prev, at);
        check("restart_latency", at - t0, 12);
        check("restart_data", d, 1);

        // Reset in WRITE_A with enable still high
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_wr_a", dac_wr_a, 0);
        check("rst_mid_wr_b", dac_wr_b, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_data", dac_data, 0);
        check("rst_mid_ready", cfg_ready, 1);
        reset = 1'b0; enable = 1'b0;
        @(negedge clk);

        // cfg_valid raised on a WAIT tick cycle together with enable drop
        do_cfg(1'b0, 2'b01, 10'd1, 16'd9);
        enable = 1'b1;
        wait_wr(1'b0, d, prev, at);
        repeat (8) @(negedge clk);
        check("tick_wait_busy", busy, 0);
        check("tick_ready_low", cfg_ready, 0);
        enable = 1'b0;
        cfg_chan = 1'b1; cfg_mode = 2'b01; cfg_step = 10'd5; cfg_div = 16'd9; cfg_valid = 1'b1;
        @(negedge clk);
        check("post_tick_ready", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("post_tick_busy", busy, 0);
        enable = 1'b1;
        t0 = cyc;
        wait_wr(1'b1, d, prev, at);
        check("newcfg_b0", d, 0);
        check("newcfg_b_latency", at - t0, 14);
        wait_wr(1'b1, d, prev, at);
        check("newcfg_b1", d, 5);

        enable = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
